// File: rtl/palindrome_pkg.sv
// Shared types for the serial palindrome checker.
package palindrome_pkg;

  // COLLECT shifts in serial bits, HOLD presents a finished word downstream
  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } pal_state_t;

endpackage

// File: rtl/palindrome_check.sv
// Combinational bitwise palindrome test of one word; leading zeros are significant.
module palindrome_check #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  output logic                  is_pal
);

  // Compare the lower half against the bit-reversed upper half; an odd middle bit is ignored
  always_comb begin
    is_pal = 1'b1;
    for (int i = 0; i < DATA_WIDTH / 2; i++) begin
      if (word[i] != word[DATA_WIDTH-1-i]) begin
        is_pal = 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_palindrome_checker.sv
// Assembles a serial bit stream MSB-first into words, flags palindromic words,
// hands each word off on a valid/ready port and counts palindromes delivered.
module serial_palindrome_checker
  import palindrome_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout_word,
  output logic                  dout_pal,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [CNT_WIDTH-1:0]  pal_count
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  pal_state_t            state_q;
  pal_state_t            state_d;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] next_word;
  logic                  next_pal;
  logic                  accept;
  logic                  handoff;
  logic                  last_beat;

  // The word as it will look once the current bit is shifted in
  generate
    if (DATA_WIDTH == 1) begin : g_single
      assign next_word = din;
    end else begin : g_multi
      assign next_word = {shreg[DATA_WIDTH-2:0], din};
    end
  endgenerate

  palindrome_check #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_check (
    .word   (next_word),
    .is_pal (next_pal)
  );

  assign last_beat = (bit_cnt == LAST_BIT);

  // Next-state and handshake decode; clear overrides any transition and kills handshakes
  always_comb begin
    state_d   = state_q;
    din_ready = 1'b0;
    accept    = 1'b0;
    handoff   = 1'b0;
    case (state_q)
      COLLECT: begin
        din_ready = 1'b1;
        accept    = din_valid && !clear;
        if (accept && last_beat) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        handoff = dout_valid && dout_ready && !clear;
        if (handoff) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
    if (clear) begin
      state_d = COLLECT;
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Shift register, bit counter and output word registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      dout_word  <= '0;
      dout_pal   <= 1'b0;
      dout_valid <= 1'b0;
    end else if (clear) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (accept) begin
        shreg <= next_word;
        if (last_beat) begin
          bit_cnt    <= '0;
          dout_word  <= next_word;
          dout_pal   <= next_pal;
          dout_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
      if (handoff) begin
        dout_valid <= 1'b0;
      end
    end
  end

  // Saturating count of palindromic words taken by downstream; survives clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pal_count <= '0;
    end else if (handoff && dout_pal && (pal_count != {CNT_WIDTH{1'b1}})) begin
      pal_count <= pal_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_serial_palindrome_checker.sv
// Directed self-checking bench: an 8-bit instance with a 2-bit counter and a 1-bit instance.
module tb_serial_palindrome_checker;

  logic clk = 1'b0;

  logic       resetn8, clear8, din8, din_valid8, din_ready8, dout_pal8, dout_valid8, dout_ready8;
  logic [7:0] dout_word8;
  logic [1:0] pal_count8;

  logic       resetn1, clear1, din1, din_valid1, din_ready1, dout_pal1, dout_valid1, dout_ready1;
  logic [0:0] dout_word1;
  logic [1:0] pal_count1;

  int compareCount = 0;
  int failCount    = 0;

  serial_palindrome_checker #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut8 (
    .clk(clk), .resetn(resetn8), .clear(clear8), .din(din8), .din_valid(din_valid8),
    .din_ready(din_ready8), .dout_word(dout_word8), .dout_pal(dout_pal8),
    .dout_valid(dout_valid8), .dout_ready(dout_ready8), .pal_count(pal_count8)
  );

  serial_palindrome_checker #(.DATA_WIDTH(1), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .resetn(resetn1), .clear(clear1), .din(din1), .din_valid(din_valid1),
    .din_ready(din_ready1), .dout_word(dout_word1), .dout_pal(dout_pal1),
    .dout_valid(dout_valid1), .dout_ready(dout_ready1), .pal_count(pal_count1)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream bits word[hi] down to word[lo] into the 8-bit instance, one per cycle
  task automatic applyBits(input logic [7:0] word, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      din8       = word[i];
      din_valid8 = 1'b1;
      tick();
    end
    din_valid8 = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] word);
    applyBits(word, 7, 0);
  endtask

  task automatic sendBit1(input logic b);
    din1       = b;
    din_valid1 = 1'b1;
    tick();
    din_valid1 = 1'b0;
  endtask

  logic [7:0] palWords [5] = '{8'h00, 8'hFF, 8'h81, 8'h18, 8'hA5};
  logic [1:0] palCounts[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    resetn8 = 1'b0; clear8 = 1'b0; din8 = 1'b0; din_valid8 = 1'b0; dout_ready8 = 1'b1;
    resetn1 = 1'b0; clear1 = 1'b0; din1 = 1'b0; din_valid1 = 1'b0; dout_ready1 = 1'b1;
    tick();
    tick();
    checkOutput("rst_word",  dout_word8,  8'h00);
    checkOutput("rst_pal",   dout_pal8,   1'b0);
    checkOutput("rst_valid", dout_valid8, 1'b0);
    checkOutput("rst_count", pal_count8,  2'd0);
    checkOutput("rst_ready", din_ready8,  1'b1);
    resetn8 = 1'b1;
    resetn1 = 1'b1;
    tick();

    // 1: 8'h99 with downstream always ready
    applyBits(8'h99, 7, 1);
    checkOutput("t1_valid_early", dout_valid8, 1'b0);
    applyBits(8'h99, 0, 0);
    checkOutput("t1_valid", dout_valid8, 1'b1);
    checkOutput("t1_word",  dout_word8,  8'h99);
    checkOutput("t1_pal",   dout_pal8,   1'b1);
    checkOutput("t1_dinrdy_hold", din_ready8, 1'b0);
    tick();
    checkOutput("t1_valid_drop", dout_valid8, 1'b0);
    checkOutput("t1_count", pal_count8, 2'd1);

    // 2: 8'h12 is not a palindrome
    applyStimulus(8'h12);
    checkOutput("t2_word", dout_word8, 8'h12);
    checkOutput("t2_pal",  dout_pal8,  1'b0);
    tick();
    checkOutput("t2_count", pal_count8, 2'd1);

    // 4: partial word dropped by clear, then clear during a handshake discards it
    dout_ready8 = 1'b0;
    applyBits(8'hE0, 7, 5);
    clear8 = 1'b1; din8 = 1'b1; din_valid8 = 1'b1;
    tick();
    clear8 = 1'b0; din_valid8 = 1'b0;
    checkOutput("t4_valid_clr", dout_valid8, 1'b0);
    applyBits(8'h3C, 7, 1);
    checkOutput("t4_no_partial", dout_valid8, 1'b0);
    applyBits(8'h3C, 0, 0);
    checkOutput("t4_valid", dout_valid8, 1'b1);
    checkOutput("t4_word",  dout_word8,  8'h3C);
    checkOutput("t4_pal",   dout_pal8,   1'b1);
    clear8 = 1'b1; dout_ready8 = 1'b1;
    tick();
    clear8 = 1'b0; dout_ready8 = 1'b0;
    checkOutput("t4_clr_valid", dout_valid8, 1'b0);
    checkOutput("t4_clr_count", pal_count8,  2'd1);

    // 3: backpressure holds the word while din_valid keeps asserting
    applyStimulus(8'h81);
    din8 = 1'b1; din_valid8 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("t3_dinrdy_%0d", c), din_ready8,  1'b0);
      checkOutput($sformatf("t3_word_%0d", c),   dout_word8,  8'h81);
      checkOutput($sformatf("t3_valid_%0d", c),  dout_valid8, 1'b1);
      tick();
    end
    dout_ready8 = 1'b1;
    tick();
    checkOutput("t3_release_valid", dout_valid8, 1'b0);
    checkOutput("t3_release_rdy",   din_ready8,  1'b1);
    checkOutput("t3_count",         pal_count8,  2'd2);
    for (int c = 0; c < 8; c++) tick();
    din_valid8 = 1'b0;
    checkOutput("t3_resume_valid", dout_valid8, 1'b1);
    checkOutput("t3_resume_word",  dout_word8,  8'hFF);
    tick();
    checkOutput("t3_sat_count", pal_count8, 2'd3);

    // 5: fresh counter, five palindromes saturate a 2-bit count
    resetn8 = 1'b0;
    #1;
    checkOutput("t5_rst_count", pal_count8, 2'd0);
    tick();
    resetn8 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(palWords[k]);
      checkOutput($sformatf("t5_pal_%0d", k), dout_pal8, 1'b1);
      tick();
      checkOutput($sformatf("t5_count_%0d", k), pal_count8, palCounts[k]);
    end

    // 6: single-bit words, then async reset while holding
    sendBit1(1'b1);
    checkOutput("t6_valid_a", dout_valid1, 1'b1);
    checkOutput("t6_word_a",  dout_word1,  1'b1);
    checkOutput("t6_pal_a",   dout_pal1,   1'b1);
    tick();
    checkOutput("t6_count_a", pal_count1, 2'd1);
    sendBit1(1'b0);
    checkOutput("t6_word_b", dout_word1, 1'b0);
    checkOutput("t6_pal_b",  dout_pal1,  1'b1);
    tick();
    checkOutput("t6_count_b", pal_count1, 2'd2);
    dout_ready1 = 1'b0;
    sendBit1(1'b1);
    checkOutput("t6_hold_valid", dout_valid1, 1'b1);
    resetn1 = 1'b0;
    #1;
    checkOutput("t6_async_valid", dout_valid1, 1'b0);
    checkOutput("t6_async_count", pal_count1,  2'd0);
    checkOutput("t6_async_rdy",   din_ready1,  1'b1);
    tick();
    resetn1 = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
